// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative MIPS multiply/divide unit:
// op-codes, FSM state encoding and the fixed completion latency.
package muldiv_pkg;

  localparam int MD_WIDTH   = 32;
  localparam int MD_LATENCY = MD_WIDTH + 2;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PREP = 2'b01,
    S_CALC = 2'b10,
    S_FIN  = 2'b11
  } state_t;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and
// for restoring the sign of results.
module md_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  output logic [WIDTH-1:0] fixed
);

  assign fixed = neg ? ((~value) + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one result bit per cycle, sign handled
// by magnitude conversion before and negation after the core loop.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             hi_we,
  output logic             lo_we
);

  state_t             state, state_next;
  logic [1:0]         op_lat;
  logic [WIDTH-1:0]   a_lat, b_lat, opnd;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [CNT_W-1:0]   cnt;
  logic               sign_q, sign_r;
  logic [WIDTH-1:0]   hi_hold, lo_hold, res_hi, res_lo;
  logic [WIDTH:0]     mul_sum, div_diff;
  logic               signed_op, div_op, mul_borrow, fire;

  // Slots 0/1: operand magnitudes (PREP); slots 2/3: hi/lo sign restore (FIN)
  logic [WIDTH-1:0]   fix_in  [4];
  logic [WIDTH-1:0]   fix_out [4];
  logic               fix_neg [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_fix
    md_sign_fix #(.WIDTH(WIDTH)) u_fix (
      .value(fix_in[gi]),
      .neg  (fix_neg[gi]),
      .fixed(fix_out[gi])
    );
  end

  always_comb begin
    signed_op  = !op_lat[0];
    div_op     = op_lat[1];
    fix_in[0]  = a_lat;
    fix_neg[0] = signed_op & a_lat[WIDTH-1];
    fix_in[1]  = b_lat;
    fix_neg[1] = signed_op & b_lat[WIDTH-1];
    fix_in[2]  = acc[2*WIDTH-1:WIDTH];
    fix_neg[2] = div_op ? sign_r : sign_q;
    fix_in[3]  = acc[WIDTH-1:0];
    fix_neg[3] = sign_q;

    // Negating a 2W product: the high half only gets the +1 carry when the low half is zero
    mul_borrow = !div_op && sign_q && (acc[WIDTH-1:0] != '0);
    res_hi     = fix_out[2] - {{(WIDTH-1){1'b0}}, mul_borrow};
    res_lo     = fix_out[3];
    if (div_op && (b_lat == '0)) begin
      res_hi = a_lat;
      res_lo = '1;
    end

    fire  = (state == S_FIN) && !cancel;
    done  = fire;
    hi_we = fire;
    lo_we = fire;
    busy  = (state != S_IDLE);
    hi_o  = fire ? res_hi : hi_hold;
    lo_o  = fire ? res_lo : lo_hold;
  end

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    acc_step = acc;
    if (div_op) begin
      if (div_diff[WIDTH]) acc_step = {acc[2*WIDTH-2:0], 1'b0};
      else                 acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      if (acc[0]) acc_step = {mul_sum, acc[WIDTH-1:1]};
      else        acc_step = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start && !cancel) state_next = S_PREP;
      S_PREP: state_next = cancel ? S_IDLE : S_CALC;
      S_CALC: begin
        if (cancel)                   state_next = S_IDLE;
        else if (cnt == CNT_W'(1))    state_next = S_FIN;
      end
      S_FIN:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      op_lat  <= '0;
      a_lat   <= '0;
      b_lat   <= '0;
      opnd    <= '0;
      acc     <= '0;
      cnt     <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      hi_hold <= '0;
      lo_hold <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start && !cancel) begin
            op_lat <= op;
            a_lat  <= a;
            b_lat  <= b;
          end
        end
        S_PREP: begin
          // Multiply: multiplier in low half; divide: dividend in low half
          opnd   <= div_op ? fix_out[1] : fix_out[0];
          acc    <= {{WIDTH{1'b0}}, (div_op ? fix_out[0] : fix_out[1])};
          sign_q <= fix_neg[0] ^ fix_neg[1];
          sign_r <= fix_neg[0];
          cnt    <= CNT_W'(WIDTH);
        end
        S_CALC: begin
          acc <= acc_step;
          cnt <= cnt - CNT_W'(1);
        end
        S_FIN: begin
          if (fire) begin
            hi_hold <= res_hi;
            lo_hold <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
